// File: rtl/calc_seq_ctrl_if.sv
// calc_seq_ctrl_if: bundles the command, ALU and UART-TX signals of the
// calculator sequencer. The master modport is the sequencer's view; the slave
// modport is the surrounding decoder/ALU/UART view.
interface calc_seq_ctrl_if #(
   parameter int RES_W = 32
);
   // command from the UART decoder
   logic [3:0]       dtype;
   logic [4:0]       operator;
   logic [15:0]      src1;
   logic [15:0]      src2;
   logic             parser_done;
   logic             busy;
   logic             overrun;
   // ALU start/done handshake
   logic             alu_start;
   logic [4:0]       alu_op;
   logic             alu_signed;
   logic [15:0]      alu_a;
   logic [15:0]      alu_b;
   logic             alu_done;
   logic             alu_err;
   logic [RES_W-1:0] alu_result;
   // TX byte stream: a byte moves on every cycle with tx_valid && tx_ready;
   // until then tx_valid and tx_data hold steady and tx_valid never drops
   // without a transfer (reset excepted).
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;

   modport master (
      input  dtype, operator, src1, src2, parser_done,
      input  alu_done, alu_err, alu_result, tx_ready,
      output busy, overrun, alu_start, alu_op, alu_signed, alu_a, alu_b,
      output tx_data, tx_valid
   );

   modport slave (
      output dtype, operator, src1, src2, parser_done,
      output alu_done, alu_err, alu_result, tx_ready,
      input  busy, overrun, alu_start, alu_op, alu_signed, alu_a, alu_b,
      input  tx_data, tx_valid
   );
endinterface

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: takes one parsed command at a time, issues it to the ALU and
// streams the result back as ASCII hex + CR LF, or "ERR" + CR LF on a fault,
// an ALU timeout or an unsupported dtype.
// Optional feature macro CALC_ZERO_SUPPRESS_EN: when defined, leading zero
// hex digits are skipped (a zero result still sends one "0").
module calc_seq_ctrl #(
   parameter int RES_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   calc_seq_ctrl_if.master bus,
   output logic [2:0]      state_dbg
);
   localparam int N  = RES_W / 4;
   localparam int DW = $clog2(N + 1);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE    = 3'd1,
      S_WAIT_ALU = 3'd2,
      S_SEND_HEX = 3'd3,
      S_SEND_ERR = 3'd4,
      S_SEND_EOL = 3'd5
   } state_t;

   state_t           state;
   logic [15:0]      to_cnt;
   logic [RES_W-1:0] res_q;     // remaining digits, next one in the top nibble
   logic [DW-1:0]    dig_left;  // digits still to present after the current one
   logic [1:0]       byte_idx;  // position within "ERR" or CR LF
   logic             tx_fire;
   logic [RES_W-1:0] cap_val;
   logic [DW-1:0]    cap_digits;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign tx_fire     = bus.tx_valid && bus.tx_ready;
   assign bus.busy    = (state != S_IDLE);
   assign bus.overrun = bus.parser_done && (state != S_IDLE);
   assign state_dbg   = state;

`ifdef CALC_ZERO_SUPPRESS_EN
   logic lead;

   // Left-align the first non-zero digit of the incoming result; the lowest
   // digit is never skipped so a zero result still produces one digit.
   always_comb begin
      cap_val    = bus.alu_result;
      cap_digits = DW'(N);
      lead       = 1'b1;
      for (int i = 0; i < N - 1; i++) begin
         if (lead && (cap_val[RES_W-1 -: 4] == 4'h0)) begin
            cap_val    = cap_val << 4;
            cap_digits = cap_digits - DW'(1);
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   // Every digit is sent, leading zeros included.
   always_comb begin
      cap_val    = bus.alu_result;
      cap_digits = DW'(N);
   end
`endif

   // Sequencer FSM: command latch, ALU handshake with timeout, TX serialiser.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         to_cnt         <= '0;
         res_q          <= '0;
         dig_left       <= '0;
         byte_idx       <= '0;
         bus.alu_start  <= 1'b0;
         bus.alu_op     <= '0;
         bus.alu_signed <= 1'b0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.tx_data    <= '0;
         bus.tx_valid   <= 1'b0;
      end else begin
         bus.alu_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.parser_done) begin
                  bus.alu_op     <= bus.operator;
                  bus.alu_signed <= (bus.dtype == 4'h2);
                  bus.alu_a      <= bus.src1;
                  bus.alu_b      <= bus.src2;
                  if ((bus.dtype == 4'h1) || (bus.dtype == 4'h2)) begin
                     state         <= S_ISSUE;
                     bus.alu_start <= 1'b1;
                  end else begin
                     state        <= S_SEND_ERR;
                     bus.tx_valid <= 1'b1;
                     bus.tx_data  <= 8'h45;
                     byte_idx     <= 2'd0;
                  end
               end
            end
            S_ISSUE: begin
               to_cnt <= '0;
               state  <= S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
               to_cnt <= to_cnt + 16'd1;
               if (bus.alu_done && !bus.alu_err) begin
                  state        <= S_SEND_HEX;
                  res_q        <= cap_val << 4;
                  dig_left     <= cap_digits - DW'(1);
                  bus.tx_valid <= 1'b1;
                  bus.tx_data  <= hex_char(cap_val[RES_W-1 -: 4]);
               end else if (bus.alu_done || (to_cnt == TO_LAST)) begin
                  state        <= S_SEND_ERR;
                  bus.tx_valid <= 1'b1;
                  bus.tx_data  <= 8'h45;
                  byte_idx     <= 2'd0;
               end
            end
            S_SEND_HEX: begin
               if (tx_fire) begin
                  if (dig_left == '0) begin
                     state       <= S_SEND_EOL;
                     bus.tx_data <= 8'h0D;
                     byte_idx    <= 2'd0;
                  end else begin
                     bus.tx_data <= hex_char(res_q[RES_W-1 -: 4]);
                     res_q       <= res_q << 4;
                     dig_left    <= dig_left - DW'(1);
                  end
               end
            end
            S_SEND_ERR: begin
               if (tx_fire) begin
                  if (byte_idx == 2'd2) begin
                     state       <= S_SEND_EOL;
                     bus.tx_data <= 8'h0D;
                     byte_idx    <= 2'd0;
                  end else begin
                     bus.tx_data <= 8'h52;
                     byte_idx    <= byte_idx + 2'd1;
                  end
               end
            end
            S_SEND_EOL: begin
               if (tx_fire) begin
                  if (byte_idx == 2'd1) begin
                     state        <= S_IDLE;
                     bus.tx_valid <= 1'b0;
                     bus.tx_data  <= '0;
                     byte_idx     <= 2'd0;
                  end else begin
                     bus.tx_data <= 8'h0A;
                     byte_idx    <= 2'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: table of commands with ALU behaviour and TX backpressure
// mode, an ALU responder, a TX monitor with a scoreboard queue, and hand-made
// sequences for stray alu_done, overrun and reset in mid-line.
module tb_calc_seq_ctrl;
   localparam int TMO = 4;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_EOL  = 3'd5;

   typedef struct {
      logic [3:0]  dtype;
      logic [4:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      int          delay;   // ALU answer delay in cycles after alu_start; 0 = never
      logic        err;
      logic [31:0] result;
      int          rmode;   // 0 ready high, 1 toggle, 2 random
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  state_dbg;
   logic [7:0]  exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          alu_starts = 0;
   int          wait_cycles = 0;
   int          ready_mode = 0;
   logic        ready_force = 1'b0;
   logic        model_done = 1'b0, model_err = 1'b0, stray_done = 1'b0;
   logic [31:0] model_result = '0;
   vec_t        cur;
   vec_t        vecs[9];

   calc_seq_ctrl_if #(.RES_W(32)) bus ();

   assign bus.alu_done   = model_done | stray_done;
   assign bus.alu_err    = model_err;
   assign bus.alu_result = model_result;

   calc_seq_ctrl #(.RES_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
   );

   // clock and watchdog
   always #5 clk = ~clk;
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected end");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void push_response(input logic err, input logic [31:0] res);
      logic [3:0] nib;
`ifdef CALC_ZERO_SUPPRESS_EN
      bit lead = 1'b1;
`endif
      if (err) begin
         exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52);
      end else begin
         for (int i = 7; i >= 0; i--) begin
            nib = res[4*i +: 4];
`ifdef CALC_ZERO_SUPPRESS_EN
            if (lead && nib == 4'h0 && i != 0) continue;
            lead = 1'b0;
`endif
            exp_q.push_back((nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h41 + 8'(nib) - 8'd10));
         end
      end
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
   endfunction

   // TX ready driver
   initial begin
      bus.tx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = !bus.tx_ready;
            2:       bus.tx_ready = 1'($urandom_range(0, 1));
            default: bus.tx_ready = ready_force;
         endcase
      end
   end

   // ALU responder: checks the issued operands, answers after cur.delay cycles
   initial begin
      forever begin
         @(negedge clk);
         if (bus.alu_start && !rst) begin
            alu_starts++;
            check("alu_a", 32'(bus.alu_a), 32'(cur.a));
            check("alu_b", 32'(bus.alu_b), 32'(cur.b));
            check("alu_op", 32'(bus.alu_op), 32'(cur.op));
            check("alu_signed", 32'(bus.alu_signed), 32'(cur.dtype == 4'h2));
            @(negedge clk);
            check("alu_start_pulse", 32'(bus.alu_start), 32'd0);
            if (cur.delay > 0) begin
               repeat (cur.delay - 1) @(posedge clk);
               #1;
               model_done = 1'b1; model_err = cur.err; model_result = cur.result;
               @(posedge clk); #1;
               model_done = 1'b0; model_err = 1'b0; model_result = $urandom;
            end
         end
      end
   end

   // TX monitor and scoreboard
   initial begin
      logic       fire, p_valid, p_ready, p_fire;
      logic [7:0] p_data;
      p_valid = 0; p_ready = 0; p_fire = 0; p_data = '0;
      forever begin
         @(negedge clk);
         fire = bus.tx_valid && bus.tx_ready;
         if (rst) begin
            p_valid = 0; p_ready = 0; p_fire = 0; p_data = '0;
         end else begin
            if (p_valid && !p_ready) begin
               check("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
               check("tx_hold_data", 32'(bus.tx_data), 32'(p_data));
            end
            if (ready_mode == 0 && p_fire && p_data != 8'h0A)
               check("tx_back_to_back", 32'(bus.tx_valid), 32'd1);
            if (p_fire && p_data == 8'h0A) begin
               check("busy_after_lf", 32'(bus.busy), 32'd0);
               check("valid_after_lf", 32'(bus.tx_valid), 32'd0);
            end
            if (state_dbg == ST_WAIT) wait_cycles++;
            if (fire) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL tx_unexpected: got %0h expected no byte", bus.tx_data);
               end else begin
                  check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
               end
            end
            p_valid = bus.tx_valid; p_ready = bus.tx_ready; p_fire = fire; p_data = bus.tx_data;
         end
      end
   end

   // drivers
   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (!bus.busy) break;
         @(negedge clk);
      end
   endtask

   task automatic start_cmd(input vec_t v, input bit push);
      wait_idle();
      cur = v;
      ready_mode = v.rmode;
      if (push) push_response(!(v.dtype == 4'h1 || v.dtype == 4'h2) || v.delay == 0 || v.err, v.result);
      @(posedge clk); #1;
      bus.dtype = v.dtype; bus.operator = v.op; bus.src1 = v.a; bus.src2 = v.b;
      bus.parser_done = 1'b1;
      @(negedge clk);
      check("overrun_when_idle", 32'(bus.overrun), 32'd0);
      @(posedge clk); #1;
      bus.parser_done = 1'b0;
      bus.dtype = 4'( $urandom); bus.src1 = 16'($urandom);
   endtask

   task automatic finish_cmd(input vec_t v, input int s0, input int w0);
      bit valid = (v.dtype == 4'h1 || v.dtype == 4'h2);
      for (int i = 0; i < 400; i++) begin
         if (!bus.busy) break;
         @(negedge clk);
      end
      check("busy_end", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("alu_start_count", 32'(alu_starts - s0), valid ? 32'd1 : 32'd0);
      if (valid) check("wait_alu_cycles", 32'(wait_cycles - w0), (v.delay == 0) ? 32'(TMO) : 32'(v.delay));
   endtask

   task automatic run_vec(input vec_t v);
      int s0, w0;
      wait_idle();
      s0 = alu_starts; w0 = wait_cycles;
      start_cmd(v, 1'b1);
      finish_cmd(v, s0, w0);
   endtask

   initial begin
      vec_t v;
      int   s0, w0;
      rst = 1'b1;
      bus.dtype = '0; bus.operator = '0; bus.src1 = '0; bus.src2 = '0; bus.parser_done = 1'b0;
      vecs[0] = '{4'h1, 5'd0,  16'h0003, 16'h0004, 3, 1'b0, 32'h0000_0007, 0}; // basic add
      vecs[1] = '{4'h2, 5'd3,  16'hFFFE, 16'h0005, 1, 1'b0, 32'hDEAD_BEEF, 1}; // letters + toggle
      vecs[2] = '{4'h1, 5'd4,  16'h0010, 16'h0000, 2, 1'b1, 32'h1234_5678, 0}; // ALU fault
      vecs[3] = '{4'h1, 5'd1,  16'h0001, 16'h0002, 0, 1'b0, 32'h0,         0}; // timeout
      vecs[4] = '{4'h2, 5'd2,  16'h8000, 16'h7FFF, 4, 1'b0, 32'h0,         2}; // done at expiry, zero
      vecs[5] = '{4'h1, 5'd31, 16'hAAAA, 16'h5555, 1, 1'b0, 32'h000A_0F00, 2};
      vecs[6] = '{4'h0, 5'd7,  16'h0101, 16'h0202, 1, 1'b0, 32'h0,         0}; // bad dtype
      vecs[7] = '{4'h2, 5'd9,  16'h1357, 16'h2468, 2, 1'b0, 32'hFFFF_FFFF, 1};
      vecs[8] = '{4'h1, 5'd5,  16'h00FF, 16'h0F0F, 3, 1'b0, 32'h9000_0001, 0};

      @(negedge clk); @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_alu_start", 32'(bus.alu_start), 32'd0);
      check("rst_alu_a", 32'(bus.alu_a), 32'd0);
      check("rst_alu_b", 32'(bus.alu_b), 32'd0);
      check("rst_alu_op", 32'(bus.alu_op), 32'd0);
      check("rst_alu_signed", 32'(bus.alu_signed), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // stray alu_done while idle is ignored
      @(posedge clk); #1 stray_done = 1'b1;
      @(posedge clk); #1 stray_done = 1'b0;
      @(negedge clk);
      check("stray_done_busy", 32'(bus.busy), 32'd0);
      check("stray_done_valid", 32'(bus.tx_valid), 32'd0);

      // bad dtype, then a second command during SEND_EOL is dropped
      v = '{4'h5, 5'd1, 16'h1111, 16'h2222, 1, 1'b0, 32'h0, 0};
      s0 = alu_starts; w0 = wait_cycles;
      start_cmd(v, 1'b1);
      for (int i = 0; i < 50; i++) begin
         if (state_dbg == ST_EOL) break;
         @(negedge clk);
      end
      check("reached_eol", 32'(state_dbg), 32'(ST_EOL));
      @(posedge clk); #1;
      bus.dtype = 4'h1; bus.operator = 5'd2; bus.src1 = 16'hBEEF; bus.src2 = 16'hCAFE;
      bus.parser_done = 1'b1;
      @(negedge clk);
      check("overrun_pulse", 32'(bus.overrun), 32'd1);
      @(posedge clk); #1 bus.parser_done = 1'b0;
      @(negedge clk);
      check("overrun_clear", 32'(bus.overrun), 32'd0);
      repeat (4) @(negedge clk);
      check("dropped_busy", 32'(bus.busy), 32'd0);
      check("dropped_alu_a", 32'(bus.alu_a), 32'h1111);
      check("dropped_alu_b", 32'(bus.alu_b), 32'h2222);
      finish_cmd(v, s0, w0);

      // reset while the third digit is waiting for tx_ready
      ready_force = 1'b0;
      v = '{4'h1, 5'd0, 16'h0012, 16'h0034, 1, 1'b0, 32'h1234_5678, 3};
      exp_q.push_back(8'h31); exp_q.push_back(8'h32);
      start_cmd(v, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (bus.tx_valid) break;
         @(negedge clk);
      end
      ready_force = 1'b1;
      @(negedge clk); @(negedge clk);
      ready_force = 1'b0;
      @(negedge clk);
      check("third_digit_valid", 32'(bus.tx_valid), 32'd1);
      check("third_digit_data", 32'(bus.tx_data), 32'h33);
      check("two_digits_sent", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk); @(negedge clk);
      check("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
      check("midrst_alu_a", 32'(bus.alu_a), 32'd0);
      rst = 1'b0;
      ready_mode = 0;
      repeat (3) @(negedge clk);
      check("midrst_no_tx", 32'(bus.tx_valid), 32'd0);
      run_vec(vecs[0]);
      run_vec(vecs[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencer between the UART command decoder and the calculator ALU.
- Latches a parsed command (dtype, operator, src1, src2) on parser_done and issues it to the ALU with a start/done handshake.
- Serialises the ALU result to the UART TX as ASCII hex followed by CR LF, or sends an "ERR" response on fault.
- Exactly one command is in flight at a time.

Parameters:
- RES_W, 32, ALU result width in bits; must be a multiple of 4. Number of hex digits N = RES_W/4.
- TIMEOUT, 255, maximum cycles to wait for alu_done after alu_start before declaring an error; range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dtype  in  4  operand type from decoder; valid values are 4'h1 (unsigned) and 4'h2 (signed)
- operator  in  5  operation code from decoder; passed through unchanged
- src1  in  16  first operand
- src2  in  16  second operand
- parser_done  in  1  one-cycle pulse; command fields are valid in this cycle
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  one-cycle pulse when parser_done arrives while busy
- alu_start  out  1  one-cycle start pulse to the ALU
- alu_op  out  5  latched operator
- alu_signed  out  1  1 when the latched dtype is 4'h2
- alu_a  out  16  latched src1
- alu_b  out  16  latched src2
- alu_done  in  1  ALU completion pulse
- alu_err  in  1  ALU fault (e.g. divide by zero); sampled only with alu_done
- alu_result  in  RES_W  ALU result; sampled only with alu_done
- tx_data  out  8  byte to the UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX can accept a byte

Behaviour:
- Reset: state IDLE. All outputs 0, including the latched operand registers, counters and the result register.
- States: IDLE, ISSUE, WAIT_ALU, SEND_HEX, SEND_ERR, SEND_EOL.
- IDLE + parser_done:
  - Latch all command fields.
  - If dtype is 4'h1 or 4'h2, go to ISSUE.
  - Otherwise go to SEND_ERR; the ALU is not started.
- ISSUE:
  - alu_start=1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT_ALU next cycle.
- WAIT_ALU:
  - The counter increments each cycle.
  - alu_done=1 with alu_err=0: capture alu_result and go to SEND_HEX.
  - alu_done=1 with alu_err=1: go to SEND_ERR.
  - Counter reaches TIMEOUT without alu_done: go to SEND_ERR.
  - alu_done in the same cycle as timeout expiry: alu_done wins.
- TX handshake:
  - tx_valid and tx_data stay stable until a cycle with tx_valid&&tx_ready; that cycle transfers the byte.
  - The next byte is presented no earlier than the following cycle.
  - tx_valid is never dropped without a transfer, except on rst.
- SEND_HEX:
  - Sends N digits, most significant nibble first.
  - Nibble 0..9 maps to 8'h30+n; nibble A..F maps to 8'h41+(n-10).
  - After the last digit transfers, go to SEND_EOL.
- SEND_ERR: sends 8'h45, 8'h52, 8'h52 ("ERR"), then goes to SEND_EOL.
- SEND_EOL: sends 8'h0D then 8'h0A, then returns to IDLE.
- Throughput: with tx_ready held at 1, the bytes of one response appear on consecutive cycles.
- Commands while busy: parser_done while busy produces an overrun pulse in the same cycle. The command is dropped and the latched fields are unchanged.
- alu_done outside WAIT_ALU is ignored.
- rst mid-operation, including mid-byte with tx_valid high: all outputs return to their reset values on the next edge. No partial line is completed.

Optional Feature:
- Macro: CALC_ZERO_SUPPRESS_EN.
- Defined: leading zero digits are skipped in SEND_HEX. At least one digit is always sent, so a result of 0 sends "0".
- Not defined: exactly N digits are always sent, including leading zeros.

Test Plan:
- Basic add: dtype=1, operator=0, src1=16'h0003, src2=16'h0004, ALU returns alu_result=32'h7 after 3 cycles.
  - Required: alu_start pulses once with alu_a=3 and alu_b=4.
  - Without the macro, TX is 30 30 30 30 30 30 30 37 0D 0A.
  - With CALC_ZERO_SUPPRESS_EN, TX is 37 0D 0A.
- Hex letters and backpressure: result 32'hDEADBEEF; tx_ready toggles 1/0 every cycle.
  - Required: bytes 44 45 41 44 42 45 45 46 0D 0A in order.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
- ALU fault: alu_done with alu_err=1 -> TX 45 52 52 0D 0A; busy falls after the 0A transfer.
- Timeout: TIMEOUT=4, alu_done never asserted -> SEND_ERR entered 4 cycles after alu_start; TX is "ERR\r\n".
- Invalid dtype and overrun:
  - dtype=4'h5: no alu_start pulse; TX is "ERR\r\n".
  - A second parser_done during SEND_EOL: overrun=1 for one cycle; the command is dropped.
- Reset mid-send: assert rst while the 3rd digit is pending -> next cycle tx_valid=0, busy=0, state IDLE.
  - A following command completes normally.
